// File: rtl/avalon_st_hdr_strip_pkg.sv
// Types and byte-count arithmetic for the header-strip stage.
package avalon_st_hdr_strip_pack;

  typedef enum logic [1:0] {
    S_HEAD  = 2'd0,
    S_BODY  = 2'd1,
    S_FLUSH = 2'd2
  } t_strip_state;

  // Bytes left after removing the header from a final beat of w-e valid bytes.
  // Zero or negative means the header consumes the whole remainder.
  function automatic int strip_bytes_left(input int w, input int e, input int h);
    return w - e - h;
  endfunction

  // Empty count of a beat whose payload was shifted up by h bytes.
  function automatic int shifted_empty(input int e, input int h);
    return e + h;
  endfunction

  // Empty count when a short final beat merges into the residue of the previous one.
  function automatic int merged_empty(input int w, input int e, input int h);
    return h + e - w;
  endfunction

endpackage

// File: rtl/generic_func_pack.sv
// Shared elaboration-time helpers used across the streaming blocks.
package generic_func_pack;

  // Bits needed to hold the values 0..n-1, never less than one.
  function automatic int log2up_func(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST style packet interface: byte 0 sits at the MSB end of data.
interface avalon_st_if #(
  parameter int DATA_WIDTH_IN_BYTES = 16
);
  localparam int EMPTY_W = generic_func_pack::log2up_func(DATA_WIDTH_IN_BYTES);

  logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
  logic                             valid;
  logic                             rdy;
  logic                             sop;
  logic                             eop;
  logic [EMPTY_W-1:0]               empty;

  modport master (output data, valid, sop, eop, empty, input rdy);
  modport slave  (input data, valid, sop, eop, empty, output rdy);
endinterface

// File: rtl/avalon_st_hdr_strip.sv
// Removes the first HEADER_BYTES of every packet and realigns the payload,
// regenerating sop/eop/empty on a registered, backpressured output.
module avalon_st_hdr_strip
  import generic_func_pack::*;
  import avalon_st_hdr_strip_pack::*;
#(
  parameter int DATA_WIDTH_IN_BYTES = 16,
  parameter int HEADER_BYTES        = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  avalon_st_if.slave  in_stream,
  avalon_st_if.master out_stream,
  output logic        err_proto
);

  localparam int W  = DATA_WIDTH_IN_BYTES;
  localparam int H  = HEADER_BYTES;
  localparam int EW = log2up_func(W);
  localparam int RW = 8 * (W - H);
  localparam int HB = 8 * H;

  generate
    if (H < 1 || H > W - 1) begin : g_bad_header
      $error("HEADER_BYTES must lie in 1..DATA_WIDTH_IN_BYTES-1");
    end
  endgenerate

  t_strip_state   state, state_d;
  logic [RW-1:0]  residue, residue_d;
  logic           sop_pending, sop_pending_d;
  logic [EW-1:0]  flush_empty, flush_empty_d;

  logic           out_free, accept, load, err_d;
  logic [8*W-1:0] o_data;
  logic           o_sop, o_eop;
  logic [EW-1:0]  o_empty;
  int             in_empty, left;

  assign out_free      = !out_stream.valid || out_stream.rdy;
  assign in_stream.rdy = rst_n && out_free && (state != S_FLUSH);
  assign accept        = in_stream.valid && in_stream.rdy;
  assign in_empty      = int'(in_stream.empty);
  assign left          = strip_bytes_left(W, in_empty, H);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d       = state;
    residue_d     = residue;
    sop_pending_d = sop_pending;
    flush_empty_d = flush_empty;
    load          = 1'b0;
    o_data        = '0;
    o_sop         = 1'b0;
    o_eop         = 1'b0;
    o_empty       = '0;
    err_d         = 1'b0;

    if (state == S_FLUSH) begin
      if (out_free) begin
        load    = 1'b1;
        o_data  = {residue, {HB{1'b0}}};
        o_eop   = 1'b1;
        o_empty = flush_empty;
        state_d = S_HEAD;
      end
    end else if (accept) begin
      // A sop inside a body abandons the old packet and restarts header handling.
      if (state == S_HEAD || in_stream.sop) begin
        err_d = (state == S_BODY) || !in_stream.sop;
        if (!in_stream.sop) begin
          state_d = S_HEAD;
        end else if (!in_stream.eop) begin
          residue_d     = in_stream.data[RW-1:0];
          sop_pending_d = 1'b1;
          state_d       = S_BODY;
        end else begin
          sop_pending_d = 1'b0;
          state_d       = S_HEAD;
          if (left > 0) begin
            load    = 1'b1;
            o_data  = {in_stream.data[RW-1:0], {HB{1'b0}}};
            o_sop   = 1'b1;
            o_eop   = 1'b1;
            o_empty = EW'(shifted_empty(in_empty, H));
          end
        end
      end else begin
        load          = 1'b1;
        o_data        = {residue, in_stream.data[8*W-1 -: HB]};
        o_sop         = sop_pending;
        sop_pending_d = 1'b0;
        residue_d     = in_stream.data[RW-1:0];
        if (in_stream.eop) begin
          if (left <= 0) begin
            o_eop   = 1'b1;
            o_empty = EW'(merged_empty(W, in_empty, H));
            state_d = S_HEAD;
          end else begin
            flush_empty_d = EW'(shifted_empty(in_empty, H));
            state_d       = S_FLUSH;
          end
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: residue is a plain register, not a memory, so it is reset along with the control state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_HEAD;
      residue     <= '0;
      sop_pending <= 1'b0;
      flush_empty <= '0;
    end else begin
      state       <= state_d;
      residue     <= residue_d;
      sop_pending <= sop_pending_d;
      flush_empty <= flush_empty_d;
    end
  end

  // Output register: held while stalled, valid drops once consumed with nothing new.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_stream.valid <= 1'b0;
      out_stream.sop   <= 1'b0;
      out_stream.eop   <= 1'b0;
      out_stream.data  <= '0;
      out_stream.empty <= '0;
      err_proto        <= 1'b0;
    end else begin
      err_proto <= err_d;
      if (out_free) begin
        out_stream.valid <= load;
        if (load) begin
          out_stream.data  <= o_data;
          out_stream.sop   <= o_sop;
          out_stream.eop   <= o_eop;
          out_stream.empty <= o_empty;
        end
      end
    end
  end

endmodule
